// File: rtl/cache_line_unpack.sv
// cache_line_unpack: accepts whole cache lines into a two-entry buffer and emits them one
// DATA_WIDTH word per cycle, word 0 first, for a job of word_total words.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, word_total job start pulse (IDLE only) and job length in words
//   line_valid/ready  cache-line handshake, line_data word 0 in the low bits
//   out_stall         downstream hold; no word is emitted while high
//   array, inc        registered output word and its valid strobe
//   size_out          registered job length, stable for the whole job
//   done              one-cycle pulse the cycle after the final word is presented
module cache_line_unpack #(
  parameter int unsigned CACHE_WIDTH = 512,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  word_total,
  input  logic                   line_valid,
  input  logic [CACHE_WIDTH-1:0] line_data,
  output logic                   line_ready,
  input  logic                   out_stall,
  output logic [DATA_WIDTH-1:0]  array,
  output logic                   inc,
  output logic [DATA_WIDTH-1:0]  size_out,
  output logic                   done
);

  localparam int unsigned WPL  = CACHE_WIDTH / DATA_WIDTH;
  localparam int unsigned IdxW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WPL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                  state_q;
  logic [CACHE_WIDTH-1:0]  buf_q [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;
  logic [IdxW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   remaining_q;
  logic [DATA_WIDTH-1:0]   lines_left_q;
  logic [DATA_WIDTH-1:0]   size_q;
  logic [DATA_WIDTH-1:0]   array_q;
  logic                    inc_q, done_q;
  // Set while the final word of the job is being presented on array.
  logic                    last_q;

  logic                    push, pop, emit, is_final;
  logic [DATA_WIDTH-1:0]   lines_needed;
  logic [DATA_WIDTH-1:0]   head_words [WPL];
  logic [DATA_WIDTH-1:0]   head_word;

  always_comb begin
    for (int i = 0; i < int'(WPL); i++) begin
      head_words[i] = buf_q[rd_ptr_q][i*DATA_WIDTH +: DATA_WIDTH];
    end
    head_word = head_words[idx_q];
  end

  // ceil(word_total / WPL) without widening word_total.
  assign lines_needed = DATA_WIDTH'(word_total / DATA_WIDTH'(WPL))
                      + DATA_WIDTH'((word_total % DATA_WIDTH'(WPL)) != '0);

  assign line_ready = (state_q == StRun) && (count_q != 2'd2) && (lines_left_q != '0);
  assign push       = line_valid && line_ready;
  assign emit       = (state_q == StRun) && (count_q != 2'd0) && !out_stall
                   && (remaining_q != '0);
  assign is_final   = (remaining_q == DATA_WIDTH'(1));
  // A partial last line is dropped as soon as its final job word leaves.
  assign pop        = emit && ((idx_q == LastIdx) || is_final);

  assign array    = array_q;
  assign inc      = inc_q;
  assign size_out = size_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      idx_q        <= '0;
      remaining_q  <= '0;
      lines_left_q <= '0;
      size_q       <= '0;
      array_q      <= '0;
      inc_q        <= 1'b0;
      done_q       <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      inc_q  <= emit;
      done_q <= 1'b0;
      if (emit) array_q <= head_word;

      if (push) begin
        buf_q[wr_ptr_q] <= line_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        StIdle: begin
          if (start) begin
            size_q       <= word_total;
            remaining_q  <= word_total;
            lines_left_q <= lines_needed;
            idx_q        <= '0;
            last_q       <= 1'b0;
            if (word_total == '0) begin
              state_q <= StFlush;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (push) lines_left_q <= lines_left_q - DATA_WIDTH'(1);
          if (emit) begin
            remaining_q <= remaining_q - DATA_WIDTH'(1);
            idx_q       <= pop ? '0 : idx_q + IdxW'(1);
            last_q      <= is_final;
          end
          // Leave RUN once the final word has been on the output for its cycle.
          if (last_q) begin
            state_q <= StFlush;
            done_q  <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_unpack.sv
module tb_cache_line_unpack;
  localparam int CW = 512;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] word_total;
  logic          line_valid;
  logic [CW-1:0] line_data;
  logic          line_ready;
  logic          out_stall;
  logic [DW-1:0] array;
  logic          inc;
  logic [DW-1:0] size_out;
  logic          done;

  cache_line_unpack #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .word_total(word_total),
    .line_valid(line_valid), .line_data(line_data), .line_ready(line_ready),
    .out_stall(out_stall), .array(array), .inc(inc), .size_out(size_out), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] mon_q[$];
  int acc_cnt, done_cnt, first_acc_cyc, first_inc_cyc, last_inc_cyc, done_cyc, start_cyc;
  bit full_seen;
  bit stop_stall;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observer, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (inc) begin
        if (mon_q.size() == 0) first_inc_cyc = cyc;
        mon_q.push_back(array);
        last_inc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (line_valid && line_ready) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        acc_cnt++;
      end
      if (line_valid && !line_ready && acc_cnt < 3) full_seen = 1'b1;
      if (start) start_cyc = cyc;
    end
  end

  function automatic logic [CW-1:0] mk_line(input int base);
    logic [CW-1:0] l;
    for (int i = 0; i < CW / DW; i++) l[i*DW +: DW] = DW'(base + i);
    return l;
  endfunction

  task automatic clear_mon();
    mon_q.delete();
    acc_cnt = 0; done_cnt = 0; first_acc_cyc = -1; first_inc_cyc = -1;
    last_inc_cyc = -1; done_cyc = -1; start_cyc = -1; full_seen = 1'b0;
  endtask

  task automatic do_start(input logic [DW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; word_total = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers consecutive lines (words 1.., 17.., 33..) until n are taken or budget runs out.
  task automatic feed(input int n, input int budget);
    int k;
    k = 0;
    line_valid = 1'b1;
    line_data  = mk_line(1);
    while (k < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      k = acc_cnt;
      line_data = mk_line(1 + 16 * k);
    end
    line_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s done_timeout got=0 exp=1", name);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_words(input string name, input int n);
    checks++;
    if (mon_q.size() != n) begin
      failures++;
      $display("FAIL %s word_count got=%0d exp=%0d", name, mon_q.size(), n);
    end
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== DW'(i + 1)) begin
        failures++;
        $display("FAIL %s word[%0d] got=%0d exp=%0d", name, i, mon_q[i], i + 1);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; word_total = '0; line_valid = 1'b0;
    line_data = '0; out_stall = 1'b0;
    #12;
    check_val("reset_inc", DW'(inc), 0);
    check_val("reset_array", array, 0);
    check_val("reset_size_out", size_out, 0);
    check_val("reset_done", DW'(done), 0);
    check_val("reset_line_ready", DW'(line_ready), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_line();
    clear_mon();
    do_start(16);
    check_val("single_size_out", size_out, 16);
    fork
      feed(1, 40);
      wait_done("single", 100);
    join
    check_words("single", 16);
    check_val("single_lines", acc_cnt, 1);
    check_val("single_done_cnt", done_cnt, 1);
    check_val("single_done_after_last", done_cyc, last_inc_cyc + 1);
    check_val("single_contiguous", last_inc_cyc - first_inc_cyc, 15);
    check_val("single_latency", first_inc_cyc - first_acc_cyc, 2);
  endtask

  task automatic test_partial_line();
    clear_mon();
    do_start(20);
    fork
      feed(3, 80);
      wait_done("partial", 200);
    join
    check_words("partial", 20);
    check_val("partial_lines", acc_cnt, 2);
    check_val("partial_done_cnt", done_cnt, 1);
    check_val("partial_ready_after", DW'(line_ready), 0);
  endtask

  task automatic test_zero_len();
    clear_mon();
    do_start(0);
    fork
      feed(1, 10);
      wait_done("zero", 20);
    join
    check_val("zero_inc_cnt", mon_q.size(), 0);
    check_val("zero_lines", acc_cnt, 0);
    check_val("zero_done_cnt", done_cnt, 1);
    check_val("zero_done_cycle", done_cyc, start_cyc + 1);
  endtask

  task automatic test_stall_toggle();
    clear_mon();
    stop_stall = 1'b0;
    do_start(48);
    fork
      feed(3, 300);
      begin
        while (!stop_stall) begin
          @(posedge clk); #1;
          out_stall = ~out_stall;
        end
        out_stall = 1'b0;
      end
      begin
        wait_done("stall", 600);
        stop_stall = 1'b1;
      end
    join
    check_words("stall", 48);
    check_val("stall_lines", acc_cnt, 3);
    check_val("stall_full_seen", DW'(full_seen), 1);
  endtask

  task automatic test_reset_mid_job();
    int b;
    clear_mon();
    do_start(32);
    fork
      feed(2, 100);
      begin
        b = 200;
        while (mon_q.size() < 5 && b > 0) begin
          @(posedge clk); #2;
          b--;
        end
        check_val("midrst_reached_5", DW'(mon_q.size() >= 5), 1);
        rst = 1'b0;
        #1;
        check_val("midrst_inc", DW'(inc), 0);
        check_val("midrst_size_out", size_out, 0);
        check_val("midrst_line_ready", DW'(line_ready), 0);
        check_val("midrst_done", DW'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    clear_mon();
    do_start(16);
    do_start(7);  // must be ignored outside IDLE
    check_val("restart_size_out", size_out, 16);
    fork
      feed(1, 40);
      wait_done("restart", 100);
    join
    check_words("restart", 16);
    check_val("restart_done_cnt", done_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_partial_line();
    test_zero_len();
    test_stall_toggle();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
